// File: rtl/cam_rgb_capture_pkg.sv
// Shared types and RGB565 field positions for the camera capture path.
// Downstream blocks use the slice constants/helpers to split PIXEL into colour fields.
package cam_rgb_capture_pkg;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        IDLE       = 2'd1,
        HI_BYTE    = 2'd2,
        LO_BYTE    = 2'd3
    } cam_state_t;

    localparam int RGB565_R_MSB = 15;
    localparam int RGB565_R_LSB = 11;
    localparam int RGB565_G_MSB = 10;
    localparam int RGB565_G_LSB = 5;
    localparam int RGB565_B_MSB = 4;
    localparam int RGB565_B_LSB = 0;

    function automatic logic [4:0] rgb565_red(input logic [15:0] pix);
        return pix[RGB565_R_MSB:RGB565_R_LSB];
    endfunction

    function automatic logic [5:0] rgb565_green(input logic [15:0] pix);
        return pix[RGB565_G_MSB:RGB565_G_LSB];
    endfunction

    function automatic logic [4:0] rgb565_blue(input logic [15:0] pix);
        return pix[RGB565_B_MSB:RGB565_B_LSB];
    endfunction

endpackage

// File: rtl/cam_rgb_capture_sync_edge.sv
// Falling-edge detection for the camera HREF/VSYNC strobes.
// The previous level is registered; the current pin level completes the edge.
module cam_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic href,
    input  logic vsync,
    output logic href_fall,
    output logic vsync_fall
);

    logic href_q;
    logic vsync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            href_q  <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            href_q  <= href;
            vsync_q <= vsync;
        end
    end

    assign href_fall  = href_q & ~href;
    assign vsync_fall = vsync_q & ~vsync;

endmodule

// File: rtl/cam_rgb_capture.sv
// Pairs camera bytes into RGB565 pixels with a valid strobe, half-rate clock
// and column/row coordinates for the frame-buffer writer.
module cam_rgb_capture
    import cam_rgb_capture_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                       i_pclk,
    input  logic                       i_rst,
    input  logic [7:0]                 CAM_RGB,
    input  logic                       HREF,
    input  logic                       VSYNC,
    output logic [15:0]                PIXEL,
    output logic                       o_pclk,
    output logic                       en,
    output logic [$clog2(IMG_W)-1:0]   o_col,
    output logic [$clog2(IMG_H)-1:0]   o_row,
    output logic                       o_sof
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

    cam_state_t state;
    cam_state_t state_next;

    logic       href_fall;
    logic       vsync_fall;
    logic       frame_clr;
    logic       cap_hi;
    logic       cap_lo;
    logic       line_end;
    logic [7:0] hi_byte;
    logic       line_has_pix;

    cam_sync_edge u_sync_edge (
        .clk        (i_pclk),
        .rst        (i_rst),
        .href       (HREF),
        .vsync      (VSYNC),
        .href_fall  (href_fall),
        .vsync_fall (vsync_fall)
    );

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            state <= WAIT_FRAME;
        end else begin
            state <= state_next;
        end
    end

    // VSYNC overrides everything once a frame has been seen; it re-arms the byte phase.
    always_comb begin
        state_next = state;
        case (state)
            WAIT_FRAME: if (vsync_fall) state_next = IDLE;
            IDLE: begin
                if (VSYNC)     state_next = HI_BYTE;
                else if (HREF) state_next = LO_BYTE;
            end
            HI_BYTE: begin
                if (VSYNC)     state_next = HI_BYTE;
                else if (HREF) state_next = LO_BYTE;
                else           state_next = IDLE;
            end
            LO_BYTE: state_next = HI_BYTE;
            default: state_next = WAIT_FRAME;
        endcase
    end

    always_comb begin
        frame_clr = 1'b0;
        cap_hi    = 1'b0;
        cap_lo    = 1'b0;
        line_end  = 1'b0;
        if (state != WAIT_FRAME) begin
            if (VSYNC) begin
                frame_clr = 1'b1;
            end else begin
                line_end = href_fall;
                cap_hi   = HREF && (state != LO_BYTE);
                cap_lo   = HREF && (state == LO_BYTE);
            end
        end
    end

    // o_col advances the cycle after en so it names the pixel while en is high.
    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            PIXEL        <= 16'h0000;
            en           <= 1'b0;
            o_pclk       <= 1'b0;
            o_sof        <= 1'b0;
            o_col        <= '0;
            o_row        <= '0;
            hi_byte      <= 8'h00;
            line_has_pix <= 1'b0;
        end else begin
            en    <= 1'b0;
            o_sof <= 1'b0;
            if (frame_clr) begin
                o_col        <= '0;
                o_row        <= '0;
                o_pclk       <= 1'b0;
                line_has_pix <= 1'b0;
            end else begin
                if (line_end) begin
                    o_col        <= '0;
                    line_has_pix <= 1'b0;
                    if (line_has_pix && (o_row != ROW_MAX)) begin
                        o_row <= o_row + ROW_W'(1);
                    end
                end else if (en && (o_col != COL_MAX)) begin
                    o_col <= o_col + COL_W'(1);
                end

                if (cap_hi) begin
                    hi_byte <= CAM_RGB;
                    o_pclk  <= 1'b1;
                end else if (cap_lo) begin
                    PIXEL        <= {hi_byte, CAM_RGB};
                    en           <= 1'b1;
                    o_pclk       <= 1'b0;
                    o_sof        <= (o_col == '0) && (o_row == '0);
                    line_has_pix <= 1'b1;
                end else begin
                    o_pclk <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_rgb_capture.sv
// Scoreboard bench for cam_rgb_capture: stimulus pushes expected pixels,
// a negedge monitor pops and compares whenever en is high.
module tb_cam_rgb_capture;

    localparam int IMG_W = 640;
    localparam int IMG_H = 480;

    typedef struct packed {
        logic [15:0] pix;
        logic [9:0]  col;
        logic [8:0]  row;
        logic        sof;
    } exp_t;

    logic        i_pclk;
    logic        i_rst;
    logic [7:0]  CAM_RGB;
    logic        HREF;
    logic        VSYNC;
    logic [15:0] PIXEL;
    logic        o_pclk;
    logic        en;
    logic [9:0]  o_col;
    logic [8:0]  o_row;
    logic        o_sof;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   en_seen      = 0;
    int   n_pushed     = 0;

    cam_rgb_capture #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .i_pclk  (i_pclk),
        .i_rst   (i_rst),
        .CAM_RGB (CAM_RGB),
        .HREF    (HREF),
        .VSYNC   (VSYNC),
        .PIXEL   (PIXEL),
        .o_pclk  (o_pclk),
        .en      (en),
        .o_col   (o_col),
        .o_row   (o_row),
        .o_sof   (o_sof)
    );

    initial i_pclk = 1'b0;
    always #5 i_pclk = ~i_pclk;

    // Inputs change 1ns after the edge, so outputs read here reflect the previous stimulus.
    task automatic applyStimulus(input logic rst, input logic href, input logic vsync,
                                 input logic [7:0] data);
        @(posedge i_pclk);
        #1;
        i_rst   = rst;
        HREF    = href;
        VSYNC   = vsync;
        CAM_RGB = data;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic expectPixel(input logic [15:0] pix, input logic [9:0] col,
                               input logic [8:0] row, input logic sof);
        exp_t e;
        e.pix = pix;
        e.col = col;
        e.row = row;
        e.sof = sof;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    task automatic sendPixel(input logic [7:0] hi, input logic [7:0] lo, input logic [9:0] col,
                             input logic [8:0] row, input logic sof);
        applyStimulus(1'b0, 1'b1, 1'b0, hi);
        applyStimulus(1'b0, 1'b1, 1'b0, lo);
        expectPixel({hi, lo}, col, row, sof);
    endtask

    task automatic gap(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 8'bx);
    endtask

    task automatic vsyncPulse();
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 8'bx);
        gap(2);
    endtask

    always @(negedge i_pclk) begin
        if (en === 1'b1) begin
            en_seen++;
            n_compared++;
            if (exp_q.size() == 0) begin
                n_mismatched++;
                $display("[TB] FAIL unexpected_en: got PIXEL=%h col=%0d row=%0d, required no pixel",
                         PIXEL, o_col, o_row);
            end else begin
                mon_e = exp_q.pop_front();
                if ({PIXEL, o_col, o_row, o_sof, o_pclk} !== {mon_e.pix, mon_e.col, mon_e.row, mon_e.sof, 1'b0}) begin
                    n_mismatched++;
                    $display("[TB] FAIL pixel: got PIXEL=%h col=%0d row=%0d sof=%b pclk=%b, required PIXEL=%h col=%0d row=%0d sof=%b pclk=0",
                             PIXEL, o_col, o_row, o_sof, o_pclk,
                             mon_e.pix, mon_e.col, mon_e.row, mon_e.sof);
                end
            end
        end
    end

    initial begin
        i_rst   = 1'b1;
        HREF    = 1'b0;
        VSYNC   = 1'b0;
        CAM_RGB = 8'h00;
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("reset_pixel", 32'(PIXEL), 32'h0);
        checkOutput("reset_en",    32'(en),    32'h0);
        checkOutput("reset_pclk",  32'(o_pclk), 32'h0);
        checkOutput("reset_sof",   32'(o_sof), 32'h0);
        checkOutput("reset_col",   32'(o_col), 32'h0);
        checkOutput("reset_row",   32'(o_row), 32'h0);

        applyStimulus(1'b0, 1'b1, 1'b0, 8'hA1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hA2);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hA3);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hA4);
        checkOutput("preframe_pclk", 32'(o_pclk), 32'h0);
        gap(2);
        checkOutput("preframe_en_count", 32'(en_seen), 32'h0);

        vsyncPulse();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h0F);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h0E);
        checkOutput("pclk_after_hi", 32'(o_pclk), 32'h1);
        expectPixel(16'h0F0E, 10'd0, 9'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h06);
        checkOutput("pclk_after_lo", 32'(o_pclk), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h08);
        expectPixel(16'h0608, 10'd1, 9'd0, 1'b0);
        gap(3);

        sendPixel(8'h11, 8'h22, 10'd0, 9'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h33);
        gap(3);
        sendPixel(8'h44, 8'h55, 10'd0, 9'd2, 1'b0);
        gap(4);
        checkOutput("pixel_hold_x", 32'(PIXEL), 32'h4455);
        checkOutput("row_after_line", 32'(o_row), 32'd3);

        applyStimulus(1'b0, 1'b1, 1'b0, 8'h77);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h88);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'bx);
        gap(2);
        checkOutput("vsync_clr_row", 32'(o_row), 32'h0);
        checkOutput("vsync_clr_col", 32'(o_col), 32'h0);
        sendPixel(8'hAA, 8'hBB, 10'd0, 9'd0, 1'b1);
        gap(3);

        for (int i = 0; i <= IMG_W; i++) begin
            sendPixel(i[7:0], ~i[7:0], (i < IMG_W - 1) ? 10'(i) : 10'(IMG_W - 1), 9'd1, 1'b0);
        end
        gap(3);
        checkOutput("line_end_col", 32'(o_col), 32'h0);

        vsyncPulse();
        for (int l = 0; l <= IMG_H; l++) begin
            sendPixel(8'hC3, l[7:0], 10'd0, (l < IMG_H - 1) ? 9'(l) : 9'(IMG_H - 1), l == 0);
            gap(2);
        end
        checkOutput("row_sat", 32'(o_row), 32'(IMG_H - 1));

        applyStimulus(1'b0, 1'b1, 1'b0, 8'h12);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h34);
        checkOutput("pclk_before_rst", 32'(o_pclk), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'bx);
        checkOutput("midrst_pixel", 32'(PIXEL), 32'h0);
        checkOutput("midrst_en",    32'(en),    32'h0);
        checkOutput("midrst_pclk",  32'(o_pclk), 32'h0);
        checkOutput("midrst_row",   32'(o_row), 32'h0);
        checkOutput("midrst_col",   32'(o_col), 32'h0);
        checkOutput("midrst_sof",   32'(o_sof), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h56);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h78);
        checkOutput("post_rst_pclk", 32'(o_pclk), 32'h0);
        gap(2);
        vsyncPulse();
        sendPixel(8'h9A, 8'hBC, 10'd0, 9'd0, 1'b1);
        gap(3);

        checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);
        checkOutput("en_count", 32'(en_seen), 32'(n_pushed));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
